// File: rtl/pc_gen.sv
// Program-counter generator for instruction fetch: boot sequencing, hold, branch redirect with
// a one-entry pending-branch buffer, and flush. Optional target alignment check: PC_ALIGN_CHECK_EN.
module pc_gen #(
    parameter int                ADDR_W   = 32,
    parameter int                STEP     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              mem_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pend_valid,
    output logic              addr_err
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] pend_pc_reg, pend_pc_next;
    logic              ce_reg, ce_next;
    logic              pend_valid_reg, pend_valid_next;
    logic              addr_err_reg, addr_err_next;

    logic              hold;
    logic [ADDR_W-1:0] flush_tgt, branch_tgt;
    logic              flush_bad, branch_bad;

    assign hold = stall | ~mem_ready;

`ifdef PC_ALIGN_CHECK_EN
    // Low log2(STEP) bits of a target must be zero; mask is all ones when STEP=1.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));

    assign flush_tgt  = flush_pc & ALIGN_MASK;
    assign branch_tgt = branch_pc & ALIGN_MASK;
    assign flush_bad  = |(flush_pc & ~ALIGN_MASK);
    assign branch_bad = |(branch_pc & ~ALIGN_MASK);
`else
    assign flush_tgt  = flush_pc;
    assign branch_tgt = branch_pc;
    assign flush_bad  = 1'b0;
    assign branch_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= BOOT;
            pc_reg         <= RESET_PC;
            pend_pc_reg    <= '0;
            ce_reg         <= 1'b0;
            pend_valid_reg <= 1'b0;
            addr_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_pc_reg    <= pend_pc_next;
            ce_reg         <= ce_next;
            pend_valid_reg <= pend_valid_next;
            addr_err_reg   <= addr_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pend_pc_next    = pend_pc_reg;
        ce_next         = ce_reg;
        pend_valid_next = pend_valid_reg;
        addr_err_next   = 1'b0;

        case (state_reg)
            BOOT: begin
                // RESET_PC is presented with ce for the first fetch; no increment yet.
                ce_next    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                ce_next = 1'b1;
                if (flush) begin
                    pc_next         = flush_tgt;
                    pend_valid_next = 1'b0;
                    addr_err_next   = flush_bad;
                end else if (hold) begin
                    if (branch_flag) begin
                        pend_pc_next    = branch_tgt;
                        pend_valid_next = 1'b1;
                        addr_err_next   = branch_bad;
                    end
                end else if (branch_flag) begin
                    pc_next         = branch_tgt;
                    pend_valid_next = 1'b0;
                    addr_err_next   = branch_bad;
                end else if (pend_valid_reg) begin
                    pc_next         = pend_pc_reg;
                    pend_valid_next = 1'b0;
                end else begin
                    pc_next = pc_reg + ADDR_W'(STEP);
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign pc         = pc_reg;
    assign ce         = ce_reg;
    assign pend_valid = pend_valid_reg;
    assign addr_err   = addr_err_reg;

endmodule
